// File: rtl/count_checker.sv
// count_checker: receive-side self-check for a free-running WIDTH-bit counter.
// Samples D on enabled cycles, verifies each step is +1 mod 2^WIDTH,
// declares lock after LOCK_COUNT consecutive good steps, and reports wrap
// events and a saturating error count. All outputs are registered.
// Optional build macro: COUNT_CHECK_HOLD_EN -- when defined, an enabled
// sample equal to the previous one is a neutral "hold" instead of a bad step.
module count_checker #(
    parameter int WIDTH      = 4,
    parameter int LOCK_COUNT = 4,
    parameter int ERR_W      = 8
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             En,
    input  logic [WIDTH-1:0] D,
    input  logic             ErrClr,
    output logic             Locked,
    output logic             Wrap,
    output logic             ErrPulse,
    output logic [ERR_W-1:0] ErrCount
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ZERO  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONES  = {WIDTH{1'b1}};
    localparam logic [7:0]       LOCK_TGT  = LOCK_COUNT[7:0];
    localparam logic [ERR_W-1:0] ERR_ZERO  = {ERR_W{1'b0}};
    localparam logic [ERR_W-1:0] ERR_ONE   = {{(ERR_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0] ERR_ONES  = {ERR_W{1'b1}};

    // Expected successor of a count value, wrapping all-ones back to zero.
    function automatic logic [WIDTH-1:0] next_count(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        r = v + {{(WIDTH-1){1'b0}}, 1'b1};
        return r;
    endfunction

    // Error counter increment that sticks at all-ones.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        logic [ERR_W-1:0] r;
        if (v == ERR_ONES) begin
            r = ERR_ONES;
        end else begin
            r = v + ERR_ONE;
        end
        return r;
    endfunction

    state_t           state_r, state_s;
    logic [WIDTH-1:0] prev_r, prev_s;
    logic [7:0]       good_r, good_s;
    logic             locked_r;
    logic             wrap_r, wrap_s;
    logic             err_pulse_r, err_s;
    logic [ERR_W-1:0] err_cnt_r, err_cnt_s;
    logic             step_good_s;
    logic             step_hold_s;

    // Classify the current sample against the previously accepted value.
    always_comb begin
        step_good_s = (D == next_count(prev_r));
`ifdef COUNT_CHECK_HOLD_EN
        step_hold_s = (D == prev_r);
`else
        step_hold_s = 1'b0;
`endif
    end

    // Next-state logic for the acquire/lock tracker and the event pulses.
    always_comb begin
        state_s = state_r;
        prev_s  = prev_r;
        good_s  = good_r;
        wrap_s  = 1'b0;
        err_s   = 1'b0;
        if (En) begin
            case (state_r)
                ST_IDLE: begin
                    // First sample only seeds the reference value.
                    prev_s  = D;
                    good_s  = 8'd0;
                    state_s = ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    if (step_hold_s) begin
                        prev_s = prev_r;
                    end else if (step_good_s) begin
                        prev_s = D;
                        good_s = good_r + 8'd1;
                        wrap_s = (prev_r == CNT_ONES);
                        if (good_s >= LOCK_TGT) begin
                            state_s = ST_LOCKED;
                        end else begin
                            state_s = ST_ACQUIRE;
                        end
                    end else begin
                        // Mismatch while acquiring restarts the run silently.
                        prev_s = D;
                        good_s = 8'd0;
                    end
                end
                ST_LOCKED: begin
                    if (step_hold_s) begin
                        prev_s = prev_r;
                    end else if (step_good_s) begin
                        prev_s = D;
                        wrap_s = (prev_r == CNT_ONES);
                    end else begin
                        prev_s  = D;
                        good_s  = 8'd0;
                        err_s   = 1'b1;
                        state_s = ST_ACQUIRE;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    prev_s  = CNT_ZERO;
                    good_s  = 8'd0;
                end
            endcase
        end else begin
            // Gaps hold everything; lock is never lost on a gap.
            state_s = state_r;
        end
    end

    // Error counter: clear wins over hold, but an error in the same cycle counts as one.
    always_comb begin
        if (ErrClr) begin
            if (err_s) begin
                err_cnt_s = ERR_ONE;
            end else begin
                err_cnt_s = ERR_ZERO;
            end
        end else if (err_s) begin
            err_cnt_s = sat_inc(err_cnt_r);
        end else begin
            err_cnt_s = err_cnt_r;
        end
    end

    // State and output registers.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r     <= ST_IDLE;
            prev_r      <= CNT_ZERO;
            good_r      <= 8'd0;
            locked_r    <= 1'b0;
            wrap_r      <= 1'b0;
            err_pulse_r <= 1'b0;
            err_cnt_r   <= ERR_ZERO;
        end else begin
            state_r     <= state_s;
            prev_r      <= prev_s;
            good_r      <= good_s;
            locked_r    <= (state_s == ST_LOCKED);
            wrap_r      <= wrap_s;
            err_pulse_r <= err_s;
            err_cnt_r   <= err_cnt_s;
        end
    end

    assign Locked   = locked_r;
    assign Wrap     = wrap_r;
    assign ErrPulse = err_pulse_r;
    assign ErrCount = err_cnt_r;

endmodule
